// File: rtl/reg_cmd_ctrl.sv
// Serial command controller: parses {WR_CMD,addr,data} / {RD_CMD,addr} byte frames,
// drives the register file and returns read data to the TX serializer.
module reg_cmd_ctrl #(
  parameter int unsigned            WIDTH      = 8,
  parameter int unsigned            ADDR       = 4,
  parameter logic [WIDTH-1:0]       WR_CMD     = 8'hAA,
  parameter logic [WIDTH-1:0]       RD_CMD     = 8'hBB,
  parameter int unsigned            RD_TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_BUSY,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             CMD_ERR,
  output logic             CTRL_BUSY
);

  localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] txd_q, txd_d;
  logic             wren_q, wren_d;
  logic             rden_q, rden_d;
  logic             txv_q, txv_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_byte_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txd_q     <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      txv_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_byte_q <= rd_byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txd_q     <= txd_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      txv_q     <= txv_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Pulse outputs are decoded from the transition so they line up with the new state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_byte_d = rd_byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txd_d     = txd_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    txv_d     = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_d = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_d = RD_ADDR;
          else                          err_d   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wren_d  = 1'b1;
          state_d = WR_EXEC;
        end
      end
      WR_EXEC: begin
        err_d   = RX_D_VLD;
        state_d = IDLE;
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR-1:0];
          rden_d  = 1'b1;
          state_d = RD_EXEC;
        end
      end
      RD_EXEC: begin
        err_d   = RX_D_VLD;
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        err_d = RX_D_VLD;
        if (RdData_VLD) begin
          rd_byte_d = RdData;
          state_d   = TX_SEND;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          txd_d   = rd_byte_q;
          txv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = txv_q;
  assign CMD_ERR   = err_q;
  assign CTRL_BUSY = busy_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_cmd_ctrl;

  localparam int RD_TO = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData = '0;
  logic       RdData_VLD = 1'b0;
  logic       TX_BUSY = 1'b0;
  logic       WrEn, RdEn, TX_D_VLD, CMD_ERR, CTRL_BUSY;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  int checks = 0;
  int errors = 0;

  reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .RD_TIMEOUT(RD_TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD), .TX_BUSY(TX_BUSY),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- register file / environment ----------------
  logic [7:0] mem [16];
  int         pend = 0;
  int         lat = 2;
  logic [3:0] rd_addr = '0;
  bit         rd_disable = 0;
  bit         stray_en = 0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge CLK);
      RdData_VLD = 1'b0;
      if (!RST) begin
        pend = 0;
      end else begin
        if (WrEn) mem[Address] = WrData;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            RdData_VLD = 1'b1;
            RdData     = mem[rd_addr];
          end
        end else if (stray_en && $urandom_range(0, 15) == 0) begin
          RdData_VLD = 1'b1;
          RdData     = 8'($urandom);
        end
        if (RdEn && !rd_disable) begin
          pend    = lat;
          rd_addr = Address;
        end
      end
    end
  end

  // ---------------- frame-level reference model ----------------
  logic [7:0] frame[$];
  bit         exec_wr = 0, exec_rd = 0, sending = 0;
  int         wait_cnt = -1;
  logic [7:0] cap = '0;
  logic       m_wren = 0, m_rden = 0, m_txv = 0, m_err = 0, m_busy = 0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_txd = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frame.delete();
      exec_wr = 0; exec_rd = 0; sending = 0; wait_cnt = -1; cap = '0;
      m_wren = 0; m_rden = 0; m_txv = 0; m_err = 0; m_busy = 0;
      m_addr = '0; m_wdata = '0; m_txd = '0;
    end else begin
      m_wren = 0; m_rden = 0; m_txv = 0; m_err = 0;
      if (exec_wr) begin
        exec_wr = 0;
        if (RX_D_VLD) m_err = 1;
      end else if (exec_rd) begin
        exec_rd  = 0;
        wait_cnt = 0;
        if (RX_D_VLD) m_err = 1;
      end else if (wait_cnt >= 0) begin
        if (RX_D_VLD) m_err = 1;
        if (RdData_VLD) begin
          cap = RdData; wait_cnt = -1; sending = 1;
        end else begin
          wait_cnt++;
          if (wait_cnt == RD_TO) begin
            wait_cnt = -1; m_err = 1;
          end
        end
      end else if (sending) begin
        if (RX_D_VLD) m_err = 1;
        if (!TX_BUSY) begin
          sending = 0; m_txv = 1; m_txd = cap;
        end
      end else if (RX_D_VLD) begin
        if (frame.size() == 0) begin
          if (RX_P_DATA == 8'hAA || RX_P_DATA == 8'hBB) frame.push_back(RX_P_DATA);
          else m_err = 1;
        end else if (frame[0] == 8'hAA && frame.size() == 1) begin
          m_addr = 4'(RX_P_DATA % 16);
          frame.push_back(RX_P_DATA);
        end else if (frame[0] == 8'hAA) begin
          m_wdata = RX_P_DATA; frame.delete(); exec_wr = 1; m_wren = 1;
        end else begin
          m_addr = 4'(RX_P_DATA % 16); frame.delete(); exec_rd = 1; m_rden = 1;
        end
      end
      m_busy = (frame.size() != 0) || exec_wr || exec_rd || (wait_cnt >= 0) || sending;
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("WrEn", WrEn, m_wren);
    chk("RdEn", RdEn, m_rden);
    chk("Address", Address, m_addr);
    chk("WrData", WrData, m_wdata);
    chk("TX_D_VLD", TX_D_VLD, m_txv);
    chk("TX_P_DATA", TX_P_DATA, m_txd);
    chk("CMD_ERR", CMD_ERR, m_err);
    chk("CTRL_BUSY", CTRL_BUSY, m_busy);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_txv(input int maxc, output bit seen, output logic [7:0] d);
    seen = 0; d = '0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (TX_D_VLD) begin
        seen = 1; d = TX_P_DATA; break;
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR, CTRL_BUSY}, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    logic [7:0] d;
    int         k, viol;

    #3 RST = 1'b0;
    #4 chk_all_zero("reset_outputs");
    idle(2);
    RST = 1'b1;
    idle(2);

    // 1: write frame
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    chk("wr_wren", WrEn, 1'b1);
    chk("wr_addr", Address, 4'h5);
    chk("wr_data", WrData, 8'h3C);
    chk("wr_rden", RdEn, 1'b0);
    chk("wr_err", CMD_ERR, 1'b0);
    idle(1);
    chk("wr_wren_once", WrEn, 1'b0);
    idle(2);

    // 2: read frame
    send_byte(8'hBB); send_byte(8'h05);
    chk("rd_rden", RdEn, 1'b1);
    chk("rd_addr", Address, 4'h5);
    wait_txv(20, seen, d);
    chk("rd_tx_seen", seen, 1'b1);
    chk("rd_tx_data", d, 8'h3C);
    chk("rd_busy_done", CTRL_BUSY, 1'b0);
    idle(2);

    // 3: TX backpressure
    TX_BUSY = 1'b1;
    send_byte(8'hBB); send_byte(8'h05);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (TX_D_VLD) viol++;
    end
    chk("bp_no_tx", viol, 0);
    TX_BUSY = 1'b0;
    @(negedge CLK);
    chk("bp_tx_vld", TX_D_VLD, 1'b1);
    chk("bp_tx_data", TX_P_DATA, 8'h3C);
    @(negedge CLK);
    chk("bp_tx_once", TX_D_VLD, 1'b0);
    idle(2);

    // 4a: bad opcode
    send_byte(8'h11);
    chk("badop_err", CMD_ERR, 1'b1);
    chk("badop_idle", CTRL_BUSY, 1'b0);
    idle(2);

    // 4b: read timeout
    rd_disable = 1;
    send_byte(8'hBB); send_byte(8'h05);
    k = 0; seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (TX_D_VLD) seen = 1;
      if (CMD_ERR) begin k = i; break; end
    end
    chk("timeout_cycle", k, 5);
    chk("timeout_no_tx", seen, 1'b0);
    chk("timeout_idle", CTRL_BUSY, 1'b0);
    rd_disable = 0;
    idle(2);

    // 4c: byte during TX_SEND
    TX_BUSY = 1'b1;
    send_byte(8'hBB); send_byte(8'h05);
    idle(4);
    send_byte(8'h77);
    chk("txsend_err", CMD_ERR, 1'b1);
    chk("txsend_busy", CTRL_BUSY, 1'b1);
    TX_BUSY = 1'b0;
    wait_txv(5, seen, d);
    chk("txsend_seen", seen, 1'b1);
    chk("txsend_data", d, 8'h3C);
    idle(2);

    // 5: address truncation and back-to-back frames
    send_byte(8'hAA); send_byte(8'hF7); send_byte(8'h9A);
    chk("trunc_wren", WrEn, 1'b1);
    chk("trunc_addr", Address, 4'h7);
    chk("trunc_data", WrData, 8'h9A);
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBB); send_byte(8'h00);
    chk("b2b_rden", RdEn, 1'b1);
    wait_txv(20, seen, d);
    chk("b2b_seen", seen, 1'b1);
    chk("b2b_data", d, 8'h01);
    idle(2);

    // 6: reset mid-frame
    send_byte(8'hAA); send_byte(8'h05);
    @(negedge CLK);
    RST = 1'b0;
    #1 chk_all_zero("midreset_outputs");
    idle(2);
    RST = 1'b1;
    send_byte(8'h3C);
    chk("midreset_err", CMD_ERR, 1'b1);
    chk("midreset_nowr", WrEn, 1'b0);
    idle(3);

    // randomized traffic against the model
    stray_en = 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      lat      = $urandom_range(1, 6);
      TX_BUSY  = ($urandom_range(0, 9) < 3);
      RX_D_VLD = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: RX_P_DATA = 8'hAA;
        3, 4, 5: RX_P_DATA = 8'hBB;
        default: RX_P_DATA = 8'($urandom);
      endcase
      if (RST == 1'b0) RST = 1'b1;
      else if ($urandom_range(0, 499) == 0) RST = 1'b0;
    end
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    RST = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
